// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for the 5-stage LC-3b pipeline.
// Keeps a shadow copy of EX/MEM/WB register usage and derives bypass selects and stalls.
module fwd_hazard_unit #(
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 3,
    parameter int NUM_SRC     = 2,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_uses,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_wr,
    input  logic                     id_load,
    input  logic                     id_mem,
    input  logic                     mem_resp,
    input  logic                     flush,
    input  logic                     cnt_clr,
    output logic [2*NUM_SRC-1:0]     ex_fwd_sel,
    output logic [NUM_SRC-1:0]       id_fwd,
    output logic                     stall_if_id,
    output logic                     bubble_ex,
    output logic                     stall_all,
    output logic [CNT_W-1:0]         stall_cnt
);

    generate
        if (REG_W < $clog2(NUM_REGS)) begin : g_bad_reg_w
            $error("REG_W is too narrow to index NUM_REGS registers");
        end
    endgenerate

    logic                     ex_v;
    logic [NUM_SRC*REG_W-1:0] ex_src;
    logic [NUM_SRC-1:0]       ex_uses;
    logic [REG_W-1:0]         ex_dest;
    logic                     ex_wr;
    logic                     ex_load;
    logic                     ex_memop;

    logic                     mem_v;
    logic [REG_W-1:0]         mem_dest;
    logic                     mem_wr;
    logic                     mem_load;
    logic                     mem_memop;

    logic                     wb_v;
    logic [REG_W-1:0]         wb_dest;
    logic                     wb_wr;

    logic                     load_use;

    // A stage produces register idx only if it is live and writes; r0 never matches when hardwired.
    function automatic logic hit(input logic v, input logic wr,
                                 input logic [REG_W-1:0] dest,
                                 input logic [REG_W-1:0] idx);
        return v && wr && (dest == idx) && !((ZERO_REG_EN != 0) && (idx == '0));
    endfunction

    always_comb begin
        stall_all  = mem_v & mem_memop & ~mem_resp;
        load_use   = 1'b0;
        id_fwd     = '0;
        ex_fwd_sel = '0;

        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_uses[k] && hit(ex_v & ex_load, ex_wr, ex_dest, id_src[k*REG_W +: REG_W]))
                load_use = 1'b1;
            id_fwd[k] = id_uses[k] & hit(wb_v, wb_wr, wb_dest, id_src[k*REG_W +: REG_W]);

            // MEM is younger than WB, so it is checked first.
            if (ex_v && ex_uses[k]) begin
                if (hit(mem_v, mem_wr, mem_dest, ex_src[k*REG_W +: REG_W]))
                    ex_fwd_sel[2*k +: 2] = mem_load ? 2'b11 : 2'b01;
                else if (hit(wb_v, wb_wr, wb_dest, ex_src[k*REG_W +: REG_W]))
                    ex_fwd_sel[2*k +: 2] = 2'b10;
            end
        end

        load_use    = load_use & id_valid & ~flush;
        stall_if_id = stall_all | load_use;
        bubble_ex   = load_use & ~stall_all;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v      <= 1'b0;
            ex_src    <= '0;
            ex_uses   <= '0;
            ex_dest   <= '0;
            ex_wr     <= 1'b0;
            ex_load   <= 1'b0;
            ex_memop  <= 1'b0;
            mem_v     <= 1'b0;
            mem_dest  <= '0;
            mem_wr    <= 1'b0;
            mem_load  <= 1'b0;
            mem_memop <= 1'b0;
            wb_v      <= 1'b0;
            wb_dest   <= '0;
            wb_wr     <= 1'b0;
        end else if (!stall_all) begin
            wb_v      <= mem_v;
            wb_dest   <= mem_dest;
            wb_wr     <= mem_wr;
            mem_v     <= ex_v;
            mem_dest  <= ex_dest;
            mem_wr    <= ex_wr;
            mem_load  <= ex_load;
            mem_memop <= ex_memop;
            // A load-use hazard or a flush turns the EX slot into a bubble.
            ex_v      <= id_valid & ~load_use & ~flush;
            ex_src    <= id_src;
            ex_uses   <= id_uses;
            ex_dest   <= id_dest;
            ex_wr     <= id_wr;
            ex_load   <= id_load;
            ex_memop  <= id_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (stall_if_id && (stall_cnt != '1))
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance plus a zero-register / 4-bit-counter instance,
// both checked every cycle against a stage-list model and by directed literal expectations.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_src;
    logic [1:0] id_uses;
    logic [2:0] id_dest;
    logic       id_wr;
    logic       id_load;
    logic       id_mem;
    logic       mem_resp;
    logic       flush;
    logic       cnt_clr;

    logic [3:0]  sel0, sel1;
    logic [1:0]  idf0, idf1;
    logic        sif0, sif1, bub0, bub1, sa0, sa1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    fwd_hazard_unit dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_uses(id_uses),
        .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load), .id_mem(id_mem),
        .mem_resp(mem_resp), .flush(flush), .cnt_clr(cnt_clr),
        .ex_fwd_sel(sel0), .id_fwd(idf0), .stall_if_id(sif0), .bubble_ex(bub0),
        .stall_all(sa0), .stall_cnt(cnt0)
    );

    fwd_hazard_unit #(.ZERO_REG_EN(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_uses(id_uses),
        .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load), .id_mem(id_mem),
        .mem_resp(mem_resp), .flush(flush), .cnt_clr(cnt_clr),
        .ex_fwd_sel(sel1), .id_fwd(idf1), .stall_if_id(sif1), .bubble_ex(bub1),
        .stall_all(sa1), .stall_cnt(cnt1)
    );

    typedef struct {
        bit       v;
        bit [2:0] src [2];
        bit [1:0] uses;
        bit [2:0] dest;
        bit       wr;
        bit       load;
        bit       mem;
    } ins_t;

    // pipe[m][0] = EX, [1] = MEM, [2] = WB for model instance m
    ins_t pipe [2][3];
    int   model_cnt [2];
    int   cnt_max [2]  = '{65535, 15};
    bit   zero_en [2]  = '{1'b0, 1'b1};

    bit [3:0] e_sel [2];
    bit [1:0] e_idf [2];
    bit       e_sif [2];
    bit       e_bub [2];
    bit       e_sa  [2];
    bit       e_lu  [2];

    int checks   = 0;
    int failures = 0;

    function automatic bit writes(int m, ins_t s, bit [2:0] r);
        return s.v && s.wr && (s.dest == r) && !(zero_en[m] && r == 3'd0);
    endfunction

    function automatic ins_t id_ins();
        ins_t i;
        i.v      = id_valid;
        i.src[0] = id_src[2:0];
        i.src[1] = id_src[5:3];
        i.uses   = id_uses;
        i.dest   = id_dest;
        i.wr     = id_wr;
        i.load   = id_load;
        i.mem    = id_mem;
        return i;
    endfunction

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 3; s++) pipe[m][s].v = 1'b0;
            model_cnt[m] = 0;
        end
    endtask

    task automatic compute_expect();
        ins_t cur;
        for (int m = 0; m < 2; m++) begin
            cur     = id_ins();
            e_sa[m] = pipe[m][1].v && pipe[m][1].mem && !mem_resp;
            e_lu[m] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (id_valid && !flush && id_uses[k] && pipe[m][0].load &&
                    writes(m, pipe[m][0], cur.src[k]))
                    e_lu[m] = 1'b1;
                e_idf[m][k] = id_uses[k] && writes(m, pipe[m][2], cur.src[k]);
                e_sel[m][2*k +: 2] = 2'd0;
                if (pipe[m][0].v && pipe[m][0].uses[k]) begin
                    if (writes(m, pipe[m][1], pipe[m][0].src[k]))
                        e_sel[m][2*k +: 2] = pipe[m][1].load ? 2'd3 : 2'd1;
                    else if (writes(m, pipe[m][2], pipe[m][0].src[k]))
                        e_sel[m][2*k +: 2] = 2'd2;
                end
            end
            e_sif[m] = e_sa[m] || e_lu[m];
            e_bub[m] = e_lu[m] && !e_sa[m];
        end
    endtask

    task automatic advance_model();
        for (int m = 0; m < 2; m++) begin
            if (cnt_clr) model_cnt[m] = 0;
            else if (e_sif[m] && model_cnt[m] < cnt_max[m]) model_cnt[m]++;
            if (!e_sa[m]) begin
                pipe[m][2]   = pipe[m][1];
                pipe[m][1]   = pipe[m][0];
                pipe[m][0]   = id_ins();
                pipe[m][0].v = id_valid && !e_lu[m] && !flush;
            end
        end
    endtask

    task automatic chk(input string name, input int m, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compute_expect();
        chk("ex_fwd_sel", 0, sel0, e_sel[0]);  chk("ex_fwd_sel", 1, sel1, e_sel[1]);
        chk("id_fwd", 0, idf0, e_idf[0]);      chk("id_fwd", 1, idf1, e_idf[1]);
        chk("stall_if_id", 0, sif0, e_sif[0]); chk("stall_if_id", 1, sif1, e_sif[1]);
        chk("bubble_ex", 0, bub0, e_bub[0]);   chk("bubble_ex", 1, bub1, e_bub[1]);
        chk("stall_all", 0, sa0, e_sa[0]);     chk("stall_all", 1, sa1, e_sa[1]);
        chk("stall_cnt", 0, cnt0, model_cnt[0]);
        chk("stall_cnt", 1, cnt1, model_cnt[1]);
        if (!rst_n) reset_model();
        else advance_model();
    endtask

    task automatic applyStimulus(input bit v, input bit [2:0] s0, input bit [2:0] s1,
                                 input bit [1:0] uses, input bit [2:0] dest, input bit wr,
                                 input bit ld, input bit mm, input bit resp, input bit fl,
                                 input bit clr);
        @(negedge clk);
        id_valid = v;    id_src  = {s1, s0}; id_uses = uses; id_dest  = dest;
        id_wr    = wr;   id_load = ld;       id_mem  = mm;   mem_resp = resp;
        flush    = fl;   cnt_clr = clr;
        #1;
        checkOutput();
    endtask

    task automatic nop(input bit resp, input bit clr);
        applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, resp, 1'b0, clr);
    endtask

    task automatic alu(input bit [2:0] s0, input bit [2:0] s1, input bit [2:0] dest);
        applyStimulus(1'b1, s0, s1, 2'b11, dest, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ldr(input bit [2:0] dest);
        applyStimulus(1'b1, 3'd6, 3'd0, 2'b01, dest, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) nop(1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sel"}, 0, sel0, 0);  chk({tag, "_sel"}, 1, sel1, 0);
        chk({tag, "_idf"}, 0, idf0, 0);  chk({tag, "_sif"}, 0, sif0, 0);
        chk({tag, "_bub"}, 0, bub0, 0);  chk({tag, "_sa"}, 0, sa0, 0);
        chk({tag, "_sa"}, 1, sa1, 0);    chk({tag, "_cnt"}, 0, cnt0, 0);
        chk({tag, "_cnt"}, 1, cnt1, 0);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog simulation did not complete actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit hold, flush_hold;
        bit v, w, ld, mm, resp, fl, clr;
        bit [2:0] s0, s1, d;
        bit [1:0] u;

        rst_n = 1'b0;
        id_valid = 0; id_src = 0; id_uses = 0; id_dest = 0; id_wr = 0;
        id_load = 0; id_mem = 0; mem_resp = 1; flush = 0; cnt_clr = 0;
        reset_model();
        nop(1'b1, 1'b0);
        nop(1'b1, 1'b0);
        check_all_zero("reset");
        rst_n = 1'b1;

        // back-to-back ALU dependency, then with one instruction in between
        alu(3'd6, 3'd7, 3'd1);
        alu(3'd1, 3'd1, 3'd2);
        nop(1'b1, 1'b0);
        chk("alu_b2b_sel", 0, sel0, 4'b0101);
        chk("alu_b2b_sel", 1, sel1, 4'b0101);
        drain();
        alu(3'd6, 3'd7, 3'd1);
        alu(3'd6, 3'd7, 3'd5);
        alu(3'd1, 3'd1, 3'd2);
        nop(1'b1, 1'b0);
        chk("alu_gap_sel", 0, sel0, 4'b1010);
        drain();

        // load-use: one bubble, then the consumer picks the load up from WB
        nop(1'b1, 1'b1);
        ldr(3'd3);
        alu(3'd3, 3'd0, 3'd4);
        chk("lu_stall", 0, sif0, 1);
        chk("lu_bubble", 0, bub0, 1);
        chk("lu_stall_all", 0, sa0, 0);
        alu(3'd3, 3'd0, 3'd4);
        chk("lu_released", 0, sif0, 0);
        chk("lu_cnt", 0, cnt0, 1);
        nop(1'b1, 1'b0);
        chk("lu_sel", 0, sel0, 4'b0010);
        drain();

        // memory wait for three cycles
        nop(1'b1, 1'b1);
        ldr(3'd3);
        nop(1'b1, 1'b0);
        repeat (3) begin
            nop(1'b0, 1'b0);
            chk("mw_stall_all", 0, sa0, 1);
            chk("mw_stall", 0, sif0, 1);
            chk("mw_bubble", 0, bub0, 0);
        end
        nop(1'b1, 1'b0);
        chk("mw_done", 0, sa0, 0);
        chk("mw_cnt", 0, cnt0, 3);
        chk("mw_cnt", 1, cnt1, 3);
        drain();

        // WB bypass into ID, and the hardwired zero register
        alu(3'd6, 3'd7, 3'd5);
        nop(1'b1, 1'b0);
        nop(1'b1, 1'b0);
        alu(3'd0, 3'd5, 3'd6);
        chk("wb_idfwd", 0, idf0, 2'b10);
        chk("wb_idfwd", 1, idf1, 2'b10);
        drain();
        alu(3'd1, 3'd2, 3'd0);
        alu(3'd0, 3'd0, 3'd1);
        nop(1'b1, 1'b0);
        chk("r0_sel", 0, sel0, 4'b0101);
        chk("r0_sel", 1, sel1, 4'b0000);
        drain();
        ldr(3'd0);
        alu(3'd0, 3'd0, 3'd4);
        chk("r0_lu", 0, sif0, 1);
        chk("r0_lu", 1, sif1, 0);
        chk("r0_bub", 1, bub1, 0);
        drain();

        // flush beats load-use
        ldr(3'd3);
        applyStimulus(1'b1, 3'd3, 3'd0, 2'b01, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fl_stall", 0, sif0, 0);
        chk("fl_bubble", 0, bub0, 0);
        nop(1'b1, 1'b0);
        chk("fl_ex_dead", 0, sel0, 4'b0000);
        drain();

        // asynchronous reset in the middle of a memory stall
        ldr(3'd3);
        nop(1'b1, 1'b0);
        nop(1'b0, 1'b0);
        chk("rst_pre", 0, sa0, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        reset_model();
        #2;
        rst_n = 1'b1;
        drain();

        // counter saturation on the narrow instance, then clear
        nop(1'b1, 1'b1);
        ldr(3'd3);
        nop(1'b1, 1'b0);
        repeat (20) nop(1'b0, 1'b0);
        nop(1'b1, 1'b0);
        chk("sat_cnt", 1, cnt1, 15);
        chk("sat_cnt", 0, cnt0, 20);
        nop(1'b1, 1'b1);
        nop(1'b1, 1'b0);
        chk("clr_cnt", 0, cnt0, 0);
        chk("clr_cnt", 1, cnt1, 0);

        // random traffic; ID holds while stalled, flush holds through a memory stall
        hold = 0; flush_hold = 0;
        v = 0; s0 = 0; s1 = 0; u = 0; d = 0; w = 0; ld = 0; mm = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                v  = $urandom_range(0, 4) != 0;
                s0 = 3'($urandom_range(0, 3));
                s1 = 3'($urandom_range(0, 3));
                u  = 2'($urandom_range(0, 3));
                d  = 3'($urandom_range(0, 3));
                w  = $urandom_range(0, 3) != 0;
                ld = $urandom_range(0, 2) == 0;
                mm = ld | ($urandom_range(0, 3) == 0);
            end
            resp = $urandom_range(0, 9) < 7;
            fl   = flush_hold ? 1'b1 : ($urandom_range(0, 19) == 0);
            clr  = $urandom_range(0, 49) == 0;
            applyStimulus(v, s0, s1, u, d, w, ld, mm, resp, fl, clr);
            hold       = e_sif[0];
            flush_hold = fl && e_sa[0];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
